pps_failover_ctrl: RTL and testbench

Monitors the four PPS candidates (ADU5A, ADU5B, G12, internal) and checks each one's period against the nominal clock count. It drives the 2-bit PPS mux select, either as written by software (manual) or by automatic failover with revert-to-preferred (auto). It sits beside the PPS mux in the TURFIO clk_i domain and takes over ownership of the select register.

---
 rtl/pps_ctrl_pkg.sv | 38 +++
 rtl/pps_period_check.sv | 87 ++++++++
 rtl/pps_failover_ctrl.sv | 121 ++++++++++++
 tb/tb_pps_failover_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pps_ctrl_pkg.sv
// Shared definitions for the PPS failover controller: FSM encoding, source indices,
// readback field positions and the failover candidate picker.
package pps_ctrl_pkg;

  typedef enum logic [1:0] {
    StManual = 2'd0,
    StLocked = 2'd1,
    StSearch = 2'd2
  } pps_state_e;

  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned SRC_ADU5A = 0;
  localparam int unsigned SRC_ADU5B = 1;
  localparam int unsigned SRC_G12   = 2;
  localparam int unsigned SRC_INT   = 3;

  localparam int unsigned DAT_PREF_LSB  = 0;
  localparam int unsigned DAT_AUTO_BIT  = 2;
  localparam int unsigned DAT_SEL_LSB   = 4;
  localparam int unsigned DAT_ST_LSB    = 6;
  localparam int unsigned DAT_VALID_LSB = 8;
  localparam int unsigned DAT_CNT_LSB   = 24;
  localparam int unsigned DAT_CLR_BIT   = 31;

  // Returns {found, index}: preferred source if valid, else lowest-index valid source.
  // The internal source has the highest index, so it is naturally the last resort.
  function automatic logic [2:0] pick_candidate(input logic [NUM_SRC-1:0] valid,
                                                input logic [1:0]         pref);
    logic [2:0] res;
    res = 3'b000;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid[i]) res = {1'b1, 2'(i)};
    end
    if (valid[pref]) res = {1'b1, pref};
    return res;
  endfunction

endpackage

// File: rtl/pps_period_check.sv
// One PPS source: 2-FF synchronizer, rising-edge detect, period counter and validity.
// Build with PPS_GLITCH_FILTER_EN to require 4 high cycles before an edge is accepted.
module pps_period_check #(
  parameter int unsigned NOM_PERIOD = 33000000,
  parameter int unsigned TOL        = 3300,
  parameter int unsigned CNT_W      = 26
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pps,
  output logic o_lvl,
  output logic o_valid
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(NOM_PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0] CntTmo = CNT_W'(NOM_PERIOD + TOL);
  localparam logic [CNT_W-1:0] CntLo  = CNT_W'(NOM_PERIOD - TOL - 1);
  localparam logic [CNT_W-1:0] CntHi  = CNT_W'(NOM_PERIOD + TOL - 1);

  logic [1:0]       r_sync;
  logic             w_lvl;
  logic             w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_good;
  logic             r_armed;
  logic             w_tmo;
  logic             w_in_win;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_pps};
  end

  assign w_lvl = r_sync[1];

`ifdef PPS_GLITCH_FILTER_EN
  logic [2:0] r_hi;

  always_ff @(posedge i_clk) begin
    if (i_rst)               r_hi <= 3'd0;
    else if (!w_lvl)         r_hi <= 3'd0;
    else if (r_hi != 3'd4)   r_hi <= r_hi + 3'd1;
  end

  // Fires once, on the fourth consecutive high cycle.
  assign w_edge = w_lvl && (r_hi == 3'd3);
`else
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= w_lvl;
  end

  assign w_edge = w_lvl && !r_prev;
`endif

  // Timeout is the cycle the counter steps onto its saturation value.
  assign w_tmo    = (r_cnt == CntTmo);
  assign w_in_win = (r_cnt >= CntLo) && (r_cnt <= CntHi);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_good  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (w_edge)              r_cnt <= '0;
      else if (r_cnt != CntMax) r_cnt <= r_cnt + 1'b1;

      if (w_tmo) begin
        r_good  <= 2'd0;
        r_armed <= 1'b0;
      end else if (w_edge) begin
        r_armed <= 1'b1;
        if (r_armed) begin
          if (w_in_win) r_good <= (r_good == 2'd2) ? 2'd2 : r_good + 2'd1;
          else          r_good <= 2'd0;
        end
      end
    end
  end

  assign o_lvl   = w_lvl;
  assign o_valid = (r_good == 2'd2);

endmodule

// File: rtl/pps_failover_ctrl.sv
// PPS mux select owner: per-source period checkers plus manual/auto failover FSM.
// Optional macro PPS_GLITCH_FILTER_EN enables the 4-cycle input glitch filter.
module pps_failover_ctrl
  import pps_ctrl_pkg::*;
#(
  parameter int unsigned NOM_PERIOD = 33000000,
  parameter int unsigned TOL        = 3300,
  parameter int unsigned CNT_W      = 26
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  pps_i,
  output logic [1:0]  sel_o,
  output logic [3:0]  src_valid_o,
  output logic        switch_o
);

  logic [NUM_SRC-1:0] w_valid;
  logic [NUM_SRC-1:0] w_lvl;
  logic [2:0]         w_cand;
  logic               w_found;
  logic [1:0]         w_cidx;
  logic               w_quiet;

  pps_state_e r_state;
  logic [1:0] r_pref;
  logic       r_auto;
  logic [1:0] r_sel;
  logic       r_switch;
  logic [7:0] r_swcnt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_chk
    pps_period_check #(
      .NOM_PERIOD (NOM_PERIOD),
      .TOL        (TOL),
      .CNT_W      (CNT_W)
    ) u_chk (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_pps   (pps_i[g]),
      .o_lvl   (w_lvl[g]),
      .o_valid (w_valid[g])
    );
  end

  assign w_cand  = pick_candidate(w_valid, r_pref);
  assign w_found = w_cand[2];
  assign w_cidx  = w_cand[1:0];
  // Both outgoing and incoming sources low, so the mux cannot emit a runt pulse.
  assign w_quiet = !w_lvl[r_sel] && !w_lvl[w_cidx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StManual;
      r_pref   <= 2'd0;
      r_auto   <= 1'b0;
      r_sel    <= 2'd0;
      r_switch <= 1'b0;
      r_swcnt  <= 8'd0;
    end else begin
      r_switch <= 1'b0;
      unique case (r_state)
        StManual: begin
          r_sel <= r_pref;
          if (r_auto) r_state <= StLocked;
        end
        StLocked: begin
          if (!r_auto) begin
            r_sel   <= r_pref;
            r_state <= StManual;
          end else if (!w_valid[r_sel]) begin
            r_state <= StSearch;
          end else if (w_valid[r_pref] && (r_sel != r_pref)) begin
            r_state <= StSearch;
          end
        end
        StSearch: begin
          if (!r_auto) begin
            r_sel   <= r_pref;
            r_state <= StManual;
          end else if (w_found) begin
            if (w_cidx == r_sel) begin
              r_state <= StLocked;
            end else if (w_quiet) begin
              r_sel    <= w_cidx;
              r_switch <= 1'b1;
              r_state  <= StLocked;
              if (r_swcnt != 8'hFF) r_swcnt <= r_swcnt + 8'd1;
            end
          end
        end
        default: r_state <= StManual;
      endcase

      // FSM above used the old pref/auto, so a write lands one cycle later.
      if (wr_i) begin
        r_pref <= dat_i[DAT_PREF_LSB +: 2];
        r_auto <= dat_i[DAT_AUTO_BIT];
        if (dat_i[DAT_CLR_BIT]) r_swcnt <= 8'd0;
      end
    end
  end

  always_comb begin
    dat_o                       = '0;
    dat_o[DAT_PREF_LSB +: 2]    = r_pref;
    dat_o[DAT_AUTO_BIT]         = r_auto;
    dat_o[DAT_SEL_LSB +: 2]     = r_sel;
    dat_o[DAT_ST_LSB +: 2]      = r_state;
    dat_o[DAT_VALID_LSB +: 4]   = w_valid;
    dat_o[DAT_CNT_LSB +: 8]     = r_swcnt;
  end

  assign sel_o       = r_sel;
  assign src_valid_o = w_valid;
  assign switch_o    = r_switch;

endmodule

// File: tb/tb_pps_failover_ctrl.sv
// Bench for pps_failover_ctrl with a small nominal period; validity is checked every cycle
// against a timestamp-based model of the period rules.
module tb_pps_failover_ctrl;

  localparam int NOM  = 100;
  localparam int TOL  = 2;
  localparam int MAXC = NOM + TOL + 1;
`ifdef PPS_GLITCH_FILTER_EN
  localparam logic FILT = 1'b1;
`else
  localparam logic FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  pps;
  logic [1:0]  sel;
  logic [3:0]  valid;
  logic        sw;

  always #5 clk = ~clk;

  pps_failover_ctrl #(
    .NOM_PERIOD (NOM),
    .TOL        (TOL),
    .CNT_W      (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_i        (wr),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .pps_i       (pps),
    .sel_o       (sel),
    .src_valid_o (valid),
    .switch_o    (sw)
  );

  // Pulse generators
  bit          en  [4];
  int          per [4];
  int          pw  [4];
  int          nxt [4];
  int          hl  [4];
  bit          rnd;
  logic [15:0] h   [4];

  // Reference model: time of last accepted edge (or reset), arm flag, good-period count
  int ref_t [4];
  int good  [4];
  bit armed [4];

  int cyc;
  int n_chk;
  int n_fail;
  int n_sw;

  typedef struct {
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rand_per();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return 98 + $urandom_range(0, 4);
    else if (r == 6) return 97;
    else if (r == 7) return 103;
    else if (r == 8) return 150;
    return 30;
  endfunction

  function automatic bit model_edge(input int i);
    if (FILT) return (h[i][5:2] == 4'hF) && !h[i][6];
    return h[i][2] && !h[i][3];
  endfunction

  task automatic tick();
    logic [1:0] sel_before;
    logic [3:0] mv;
    int         d;
    bit         e;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && cyc == nxt[i]) begin
        hl[i]  = rnd ? int'($urandom_range(1, 8)) : pw[i];
        nxt[i] = nxt[i] + (rnd ? rand_per() : per[i]);
      end
      pps[i] = (hl[i] > 0);
      if (hl[i] > 0) hl[i]--;
      h[i] = {h[i][14:0], pps[i]};
    end
    sel_before = sel;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        ref_t[i] = cyc;
        good[i]  = 0;
        armed[i] = 0;
        h[i]     = '0;
      end else begin
        e = model_edge(i);
        d = cyc - ref_t[i];
        if (d == MAXC) begin
          good[i]  = 0;
          armed[i] = 0;
        end else if (e) begin
          if (armed[i]) begin
            if (d >= NOM - TOL && d <= NOM + TOL) good[i] = (good[i] < 2) ? good[i] + 1 : 2;
            else good[i] = 0;
          end
          armed[i] = 1;
        end
        if (e) ref_t[i] = cyc;
      end
      mv[i] = (good[i] == 2);
    end
    #1;
    chk("src_valid", {28'd0, valid}, {28'd0, mv});
    if (sw === 1'b1) begin
      n_sw++;
      chk("switch_runt", {30'd0, h[sel_before][2], h[sel][2]}, 32'd0);
    end
  endtask

  task automatic write(input logic [31:0] d);
    wr    = 1'b1;
    dat_i = d;
    tick();
    wr    = 1'b0;
    dat_i = '0;
  endtask

  task automatic wait_sel(input logic [1:0] s, input int budget, input string nm);
    int k;
    k = 0;
    while (sel !== s && k < budget) begin
      tick();
      k++;
    end
    chk(nm, {30'd0, sel}, {30'd0, s});
  endtask

  task automatic start_src(input int i, input int p, input int w, input int ofs);
    per[i] = p;
    pw[i]  = w;
    nxt[i] = cyc + ofs;
    en[i]  = 1'b1;
  endtask

  task automatic stop_all();
    for (int i = 0; i < 4; i++) en[i] = 1'b0;
  endtask

  initial begin
    int n_sw0;
    int k;
    n_chk = 0; n_fail = 0; n_sw = 0; cyc = 0; rnd = 1'b0;
    rst = 1'b1; wr = 1'b0; dat_i = '0; pps = '0;
    for (int i = 0; i < 4; i++) begin
      en[i] = 0; per[i] = 0; pw[i] = 0; nxt[i] = 0; hl[i] = 0; h[i] = '0;
      ref_t[i] = 0; good[i] = 0; armed[i] = 0;
    end

    tbl[0] = '{32'h0000_0001, 32'h0000_0011};
    tbl[1] = '{32'h00FF_FF03, 32'h0000_0033};
    tbl[2] = '{32'h0000_0005, 32'h0000_0095};
    tbl[3] = '{32'h0000_0002, 32'h0000_0022};
    tbl[4] = '{32'h0000_0007, 32'h0000_00B7};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{32'h8000_0000, 32'h0000_0000};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_switch", {31'd0, sw}, 32'd0);

    // Register/readback table with no valid source
    for (int v = 0; v < 7; v++) begin
      n_sw0 = n_sw;
      write(tbl[v].wdat);
      repeat (3) tick();
      chk("reg_vec", dat_o, tbl[v].exp);
      chk("reg_vec_noswitch", n_sw, n_sw0);
    end

    // Nominal period on ADU5A
    start_src(0, 100, 5, 10);
    repeat (320) tick();
    chk("t1_valid", {28'd0, valid}, 32'h1);

    // Late period on ADU5B never validates; early period drops ADU5A
    start_src(1, 103, 5, 7);
    repeat (450) tick();
    chk("t2_late", {31'd0, valid[1]}, 32'd0);
    per[0] = 97;
    repeat (250) tick();
    chk("t2_early", {31'd0, valid[0]}, 32'd0);
    stop_all();
    repeat (120) tick();
    chk("t2_all_invalid", {28'd0, valid}, 32'd0);

    // Auto failover from ADU5A to G12
    rst = 1'b1; tick(); rst = 1'b0;
    write(32'h0000_0004);
    start_src(0, 100, 5, 10);
    start_src(2, 100, 80, 47);
    n_sw0 = n_sw;
    repeat (330) tick();
    chk("t3_locked_sel", {30'd0, sel}, 32'd0);
    chk("t3_locked_state", {30'd0, dat_o[7:6]}, 32'd1);
    chk("t3_valid", {28'd0, valid}, 32'h5);
    chk("t3_no_pulse", n_sw, n_sw0);
    en[0] = 1'b0;
    wait_sel(2'd2, 400, "t3_failover_sel");
    chk("t3_pulses", n_sw - n_sw0, 32'd1);
    chk("t3_count", {24'd0, dat_o[31:24]}, 32'd1);

    // Revert to preferred, then clear the counter
    n_sw0 = n_sw;
    start_src(0, 100, 5, 5);
    wait_sel(2'd0, 500, "t4_revert_sel");
    chk("t4_pulses", n_sw - n_sw0, 32'd1);
    chk("t4_count", {24'd0, dat_o[31:24]}, 32'd2);
    write(32'h8000_0004);
    tick();
    chk("t4_clear", {24'd0, dat_o[31:24]}, 32'd0);

    // Manual select, then reset while searching
    n_sw0 = n_sw;
    write(32'h0000_0003);
    tick();
    chk("t5_manual_sel", {30'd0, sel}, 32'd3);
    repeat (8) tick();
    chk("t5_no_pulse", n_sw, n_sw0);
    stop_all();
    repeat (120) tick();
    write(32'h0000_0005);
    repeat (3) tick();
    chk("t5_search", {30'd0, dat_o[7:6]}, 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_dat", dat_o, 32'd0);
    chk("t5_rst_sel", {30'd0, sel}, 32'd0);
    chk("t5_rst_switch", {31'd0, sw}, 32'd0);

    // Short glitch mid-period on a valid source
    start_src(0, 100, 5, 10);
    repeat (320) tick();
    chk("t6_pre_valid", {31'd0, valid[0]}, 32'd1);
    k = 0;
    while (cyc != nxt[0] - 50 && k < 200) begin
      tick();
      k++;
    end
    hl[0] = 2;
    repeat (15) tick();
    chk("t6_glitch", {31'd0, valid[0]}, {31'd0, FILT});
    stop_all();

    // Randomised periods and widths on all sources
    rst = 1'b1; tick(); rst = 1'b0;
    rnd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hl[i]  = 0;
      nxt[i] = cyc + int'($urandom_range(1, 50));
      en[i]  = 1'b1;
    end
    repeat (3000) tick();
    chk("rand_no_pulse", {31'd0, sw}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
